// File: rtl/button_event_conditioner.sv
// Turns three raw push-button levels into clean, mutually exclusive one-cycle
// inc/dec/clr command pulses: synchronise, tick-sample, debounce, press FSM with auto-repeat.
module button_event_conditioner #(
    parameter int unsigned CLOCK_FREQ     = 100_000_000,
    parameter int unsigned SAMPLE_MS      = 10,
    parameter int unsigned STABLE_SAMPLES = 3,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10,
    parameter int unsigned REPEAT_EN      = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_pulse,
    output logic [2:0] held
);

    localparam int unsigned TICK_RAW = (CLOCK_FREQ / 1000) * SAMPLE_MS;
    localparam int unsigned TICK_DIV = (TICK_RAW < 2) ? 2 : TICK_RAW;
    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned AGREE_W  = 4;
    localparam int unsigned TMAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TIMER_W  = $clog2(TMAX + 1);

    typedef enum logic [1:0] {P_IDLE, P_DELAY, P_REPEAT} press_state_e;
    typedef enum logic {C_IDLE, C_HELD} clr_state_e;

    logic [2:0]         sync1_q, sync2_q;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic               tick_c;
    logic [2:0]         stable_q, stable_d;
    logic [2:0]         rise_c;
    logic [AGREE_W-1:0] agree_q [3];
    logic [AGREE_W-1:0] agree_d [3];
    press_state_e       press_q [2];
    press_state_e       press_d [2];
    logic [TIMER_W-1:0] timer_q [2];
    logic [TIMER_W-1:0] timer_d [2];
    clr_state_e         clr_st_q, clr_st_d;
    logic [2:0]         req_c;
    logic               inc_q, inc_d, dec_q, dec_d, clr_q, clr_d;

    // State register; bit order everywhere is {clr, down, up}
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            stable_q   <= '0;
            for (int i = 0; i < 3; i++) agree_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= P_IDLE;
                timer_q[i] <= '0;
            end
            clr_st_q <= C_IDLE;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            sync1_q    <= {btn_clr, btn_down, btn_up};
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            stable_q   <= stable_d;
            for (int i = 0; i < 3; i++) agree_q[i] <= agree_d[i];
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= press_d[i];
                timer_q[i] <= timer_d[i];
            end
            clr_st_q <= clr_st_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        tick_c     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        stable_d   = stable_q;
        req_c      = '0;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        clr_d      = 1'b0;
        clr_st_d   = clr_st_q;

        // Debounce: a level flips only after STABLE_SAMPLES consecutive disagreeing samples
        for (int i = 0; i < 3; i++) begin
            agree_d[i] = agree_q[i];
            if (tick_c) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (agree_q[i] + AGREE_W'(1) == AGREE_W'(STABLE_SAMPLES)) begin
                        stable_d[i] = ~stable_q[i];
                        agree_d[i]  = '0;
                    end else begin
                        agree_d[i] = agree_q[i] + AGREE_W'(1);
                    end
                end else begin
                    agree_d[i] = '0;
                end
            end
        end
        rise_c = stable_d & ~stable_q;

        // Up/down press FSMs; a release always wins over a same-cycle timer expiry
        for (int i = 0; i < 2; i++) begin
            press_d[i] = press_q[i];
            timer_d[i] = timer_q[i];
            case (press_q[i])
                P_IDLE: begin
                    if (rise_c[i]) begin
                        req_c[i]   = 1'b1;
                        timer_d[i] = TIMER_W'(REPEAT_DELAY);
                        press_d[i] = P_DELAY;
                    end
                end
                P_DELAY, P_REPEAT: begin
                    if (!stable_d[i]) begin
                        press_d[i] = P_IDLE;
                        timer_d[i] = '0;
                    end else if (tick_c && timer_q[i] != '0) begin
                        timer_d[i] = timer_q[i] - TIMER_W'(1);
                        if (timer_q[i] == TIMER_W'(1) &&
                            (press_q[i] == P_REPEAT || REPEAT_EN != 0)) begin
                            req_c[i]   = 1'b1;
                            timer_d[i] = TIMER_W'(REPEAT_RATE);
                            press_d[i] = P_REPEAT;
                        end
                    end
                end
                default: begin
                    press_d[i] = P_IDLE;
                    timer_d[i] = '0;
                end
            endcase
        end

        case (clr_st_q)
            C_IDLE: begin
                if (stable_d[2]) begin
                    req_c[2] = 1'b1;
                    clr_st_d = C_HELD;
                end
            end
            C_HELD: if (!stable_d[2]) clr_st_d = C_IDLE;
            default: clr_st_d = C_IDLE;
        endcase

        // Clear wins; a held clear masks up/down; simultaneous up+down cancel
        if (req_c[2]) begin
            clr_d = 1'b1;
        end else if (!stable_d[2] && !(req_c[0] && req_c[1])) begin
            inc_d = req_c[0];
            dec_d = req_c[1];
        end
    end

    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign clr_pulse = clr_q;
    assign held      = stable_q;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner with TICK_DIV=4, 3 stable samples,
// repeat delay 5 ticks and rate 2 ticks; a second instance has auto-repeat disabled.
module tb_button_event_conditioner;

    logic       clk;
    logic       reset_n;
    logic       btn_up, btn_down, btn_clr;
    logic       inc_pulse, dec_pulse, clr_pulse;
    logic [2:0] held;
    logic       nr_inc, nr_dec, nr_clr;
    logic [2:0] nr_held;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc;

    int inc_ev[$], dec_ev[$], clr_ev[$];
    int nr_inc_ev[$], nr_dec_ev[$], nr_clr_ev[$];
    int h0_rise[$], h0_fall[$], h2_fall[$];
    int held0_hi   = 0;
    int multi_err  = 0;
    int consec_err = 0;
    logic [2:0] held_prev = '0;
    logic [2:0] pulse_prev = '0;

    button_event_conditioner #(
        .CLOCK_FREQ(1000), .SAMPLE_MS(4), .STABLE_SAMPLES(3),
        .REPEAT_DELAY(5), .REPEAT_RATE(2), .REPEAT_EN(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .clr_pulse(clr_pulse),
        .held(held)
    );

    button_event_conditioner #(
        .CLOCK_FREQ(1000), .SAMPLE_MS(4), .STABLE_SAMPLES(3),
        .REPEAT_DELAY(5), .REPEAT_RATE(2), .REPEAT_EN(0)
    ) u_dut_norep (
        .clk(clk), .reset_n(reset_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .inc_pulse(nr_inc), .dec_pulse(nr_dec), .clr_pulse(nr_clr),
        .held(nr_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since the last reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Event recorder: cycle stamps of every pulse and held edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (inc_pulse) inc_ev.push_back(cyc);
            if (dec_pulse) dec_ev.push_back(cyc);
            if (clr_pulse) clr_ev.push_back(cyc);
            if (nr_inc) nr_inc_ev.push_back(cyc);
            if (nr_dec) nr_dec_ev.push_back(cyc);
            if (nr_clr) nr_clr_ev.push_back(cyc);
            if (held[0] && !held_prev[0]) h0_rise.push_back(cyc);
            if (!held[0] && held_prev[0]) h0_fall.push_back(cyc);
            if (!held[2] && held_prev[2]) h2_fall.push_back(cyc);
            if (held[0]) held0_hi++;
            if (int'(inc_pulse) + int'(dec_pulse) + int'(clr_pulse) > 1) multi_err++;
            if ((inc_pulse && pulse_prev[0]) || (dec_pulse && pulse_prev[1]) ||
                (clr_pulse && pulse_prev[2])) consec_err++;
            held_prev  = held;
            pulse_prev = {clr_pulse, dec_pulse, inc_pulse};
        end else begin
            held_prev  = '0;
            pulse_prev = '0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic test_reset();
        int s_inc, s_dec, s_clr;
        @(negedge clk);
        reset_n = 1'b0;
        btn_up = 1'b1; btn_down = 1'b1; btn_clr = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({inc_pulse, dec_pulse, clr_pulse, held} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 000000", {inc_pulse, dec_pulse, clr_pulse, held});
        end
        tests_run++;
        if ({nr_inc, nr_dec, nr_clr, nr_held} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs_norep: got %b expected 000000", {nr_inc, nr_dec, nr_clr, nr_held});
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        reset_n = 1'b1;
        s_inc = inc_ev.size(); s_dec = dec_ev.size(); s_clr = clr_ev.size();
        wait_until(24);
        tests_run++;
        if (held !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_idle_held: got %b expected 000", held);
        end
        tests_run++;
        if ((inc_ev.size() - s_inc) + (dec_ev.size() - s_dec) + (clr_ev.size() - s_clr) !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle_pulses: got %0d pulses expected 0",
                     (inc_ev.size() - s_inc) + (dec_ev.size() - s_dec) + (clr_ev.size() - s_clr));
        end
    endtask

    task automatic test_single_press();
        int s_inc, s_dec, s_clr, s_r, s_f, got;
        do_reset();
        s_inc = inc_ev.size(); s_dec = dec_ev.size(); s_clr = clr_ev.size();
        s_r = h0_rise.size(); s_f = h0_fall.size();
        wait_until(9);  btn_up = 1'b1;
        wait_until(25); btn_up = 1'b0;
        wait_until(50);
        tests_run++;
        if (inc_ev.size() - s_inc !== 1) begin
            tests_failed++;
            $display("FAIL press_inc_count: got %0d expected 1", inc_ev.size() - s_inc);
        end
        got = (inc_ev.size() > s_inc) ? inc_ev[s_inc] : -1;
        tests_run++;
        if (got !== 20) begin
            tests_failed++;
            $display("FAIL press_inc_cycle: got %0d expected 20", got);
        end
        got = (h0_rise.size() > s_r) ? h0_rise[s_r] : -1;
        tests_run++;
        if (got !== 20) begin
            tests_failed++;
            $display("FAIL press_held_rise: got %0d expected 20", got);
        end
        got = (h0_fall.size() > s_f) ? h0_fall[s_f] : -1;
        tests_run++;
        if (got !== 36) begin
            tests_failed++;
            $display("FAIL press_held_fall: got %0d expected 36", got);
        end
        tests_run++;
        if ((dec_ev.size() - s_dec) + (clr_ev.size() - s_clr) !== 0) begin
            tests_failed++;
            $display("FAIL press_other_pulses: got %0d expected 0",
                     (dec_ev.size() - s_dec) + (clr_ev.size() - s_clr));
        end
    endtask

    task automatic test_glitch();
        int s_inc, s_hi;
        do_reset();
        s_inc = inc_ev.size(); s_hi = held0_hi;
        for (int j = 0; j < 5; j++) begin
            wait_until(9 + 12 * j);  btn_up = 1'b1;
            wait_until(15 + 12 * j); btn_up = 1'b0;
        end
        wait_until(100);
        tests_run++;
        if (inc_ev.size() - s_inc !== 0) begin
            tests_failed++;
            $display("FAIL glitch_inc_count: got %0d expected 0", inc_ev.size() - s_inc);
        end
        tests_run++;
        if (held0_hi - s_hi !== 0) begin
            tests_failed++;
            $display("FAIL glitch_held_cycles: got %0d expected 0", held0_hi - s_hi);
        end
    endtask

    task automatic test_repeat();
        int s_dec, s_nr, s_nri, got;
        int exp_cyc[6];
        exp_cyc = '{20, 40, 48, 56, 64, 72};
        do_reset();
        s_dec = dec_ev.size(); s_nr = nr_dec_ev.size(); s_nri = nr_inc_ev.size() + nr_clr_ev.size();
        wait_until(9);  btn_down = 1'b1;
        wait_until(69); btn_down = 1'b0;
        wait_until(100);
        tests_run++;
        if (dec_ev.size() - s_dec !== 6) begin
            tests_failed++;
            $display("FAIL repeat_dec_count: got %0d expected 6", dec_ev.size() - s_dec);
        end
        for (int k = 0; k < 6; k++) begin
            got = (dec_ev.size() > s_dec + k) ? dec_ev[s_dec + k] : -1;
            tests_run++;
            if (got !== exp_cyc[k]) begin
                tests_failed++;
                $display("FAIL repeat_dec_cycle%0d: got %0d expected %0d", k, got, exp_cyc[k]);
            end
        end
        tests_run++;
        if (nr_dec_ev.size() - s_nr !== 1) begin
            tests_failed++;
            $display("FAIL norep_dec_count: got %0d expected 1", nr_dec_ev.size() - s_nr);
        end
        got = (nr_dec_ev.size() > s_nr) ? nr_dec_ev[s_nr] : -1;
        tests_run++;
        if (got !== 20) begin
            tests_failed++;
            $display("FAIL norep_dec_cycle: got %0d expected 20", got);
        end
        tests_run++;
        if (nr_inc_ev.size() + nr_clr_ev.size() - s_nri !== 0) begin
            tests_failed++;
            $display("FAIL norep_other_pulses: got %0d expected 0", nr_inc_ev.size() + nr_clr_ev.size() - s_nri);
        end
    endtask

    task automatic test_up_down_same();
        int s_inc, s_dec;
        do_reset();
        s_inc = inc_ev.size(); s_dec = dec_ev.size();
        wait_until(9);  btn_up = 1'b1; btn_down = 1'b1;
        wait_until(24);
        tests_run++;
        if (held[1:0] !== 2'b11) begin
            tests_failed++;
            $display("FAIL updown_held: got %b expected 11", held[1:0]);
        end
        wait_until(29); btn_up = 1'b0; btn_down = 1'b0;
        wait_until(60);
        tests_run++;
        if ((inc_ev.size() - s_inc) + (dec_ev.size() - s_dec) !== 0) begin
            tests_failed++;
            $display("FAIL updown_pulses: got %0d expected 0", (inc_ev.size() - s_inc) + (dec_ev.size() - s_dec));
        end
    endtask

    task automatic test_clr_vs_up();
        int s_inc, s_clr, got;
        do_reset();
        s_inc = inc_ev.size(); s_clr = clr_ev.size();
        wait_until(9);  btn_up = 1'b1; btn_clr = 1'b1;
        wait_until(23); btn_up = 1'b0; btn_clr = 1'b0;
        wait_until(50);
        got = (clr_ev.size() > s_clr) ? clr_ev[s_clr] : -1;
        tests_run++;
        if (got !== 20 || clr_ev.size() - s_clr !== 1) begin
            tests_failed++;
            $display("FAIL clrup_clr: got cycle %0d count %0d expected cycle 20 count 1", got, clr_ev.size() - s_clr);
        end
        tests_run++;
        if (inc_ev.size() - s_inc !== 0) begin
            tests_failed++;
            $display("FAIL clrup_inc_count: got %0d expected 0", inc_ev.size() - s_inc);
        end
    endtask

    task automatic test_clr_masks_repeat();
        int s_inc, s_clr, s_dec, got;
        do_reset();
        s_inc = inc_ev.size(); s_clr = clr_ev.size(); s_dec = dec_ev.size();
        wait_until(9);  btn_up = 1'b1;
        wait_until(29); btn_clr = 1'b1;
        wait_until(69); btn_up = 1'b0; btn_clr = 1'b0;
        wait_until(100);
        got = (inc_ev.size() > s_inc) ? inc_ev[s_inc] : -1;
        tests_run++;
        if (got !== 20 || inc_ev.size() - s_inc !== 1) begin
            tests_failed++;
            $display("FAIL mask_inc: got cycle %0d count %0d expected cycle 20 count 1", got, inc_ev.size() - s_inc);
        end
        got = (clr_ev.size() > s_clr) ? clr_ev[s_clr] : -1;
        tests_run++;
        if (got !== 40 || clr_ev.size() - s_clr !== 1) begin
            tests_failed++;
            $display("FAIL mask_clr: got cycle %0d count %0d expected cycle 40 count 1", got, clr_ev.size() - s_clr);
        end
        tests_run++;
        if (dec_ev.size() - s_dec !== 0) begin
            tests_failed++;
            $display("FAIL mask_dec_count: got %0d expected 0", dec_ev.size() - s_dec);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int s_inc, got;
        do_reset();
        wait_until(9); btn_up = 1'b1;
        wait_until(50);
        tests_run++;
        if (held[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_held_before: got %b expected 1", held[0]);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({inc_pulse, dec_pulse, clr_pulse, held} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midrst_async_clear: got %b expected 000000", {inc_pulse, dec_pulse, clr_pulse, held});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        s_inc = inc_ev.size();
        wait_until(20);
        got = (inc_ev.size() > s_inc) ? inc_ev[s_inc] : -1;
        tests_run++;
        if (got !== 12) begin
            tests_failed++;
            $display("FAIL midrst_fresh_press: got %0d expected 12", got);
        end
        btn_up = 1'b0;
        wait_until(60);
    endtask

    task automatic test_clr_long();
        int s_clr, s_f, s_oth, got;
        do_reset();
        s_clr = clr_ev.size(); s_f = h2_fall.size(); s_oth = inc_ev.size() + dec_ev.size();
        wait_until(9);   btn_clr = 1'b1;
        wait_until(100);
        tests_run++;
        if (held[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL clrlong_held: got %b expected 1", held[2]);
        end
        wait_until(109); btn_clr = 1'b0;
        wait_until(140);
        tests_run++;
        if (clr_ev.size() - s_clr !== 1) begin
            tests_failed++;
            $display("FAIL clrlong_count: got %0d expected 1", clr_ev.size() - s_clr);
        end
        got = (clr_ev.size() > s_clr) ? clr_ev[s_clr] : -1;
        tests_run++;
        if (got !== 20) begin
            tests_failed++;
            $display("FAIL clrlong_cycle: got %0d expected 20", got);
        end
        got = (h2_fall.size() > s_f) ? h2_fall[s_f] : -1;
        tests_run++;
        if (got !== 120) begin
            tests_failed++;
            $display("FAIL clrlong_held_fall: got %0d expected 120", got);
        end
        tests_run++;
        if (inc_ev.size() + dec_ev.size() - s_oth !== 0) begin
            tests_failed++;
            $display("FAIL clrlong_other: got %0d expected 0", inc_ev.size() + dec_ev.size() - s_oth);
        end
    endtask

    task automatic test_invariants();
        tests_run++;
        if (multi_err !== 0) begin
            tests_failed++;
            $display("FAIL onehot_pulses: got %0d violations expected 0", multi_err);
        end
        tests_run++;
        if (consec_err !== 0) begin
            tests_failed++;
            $display("FAIL consecutive_pulses: got %0d violations expected 0", consec_err);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_repeat();
        test_up_down_same();
        test_clr_vs_up();
        test_clr_masks_repeat();
        test_reset_mid_repeat();
        test_clr_long();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
